spi_master_core: RTL and testbench

Parametrised, self-contained SPI master engine replacing the vendor SPI IP plus control-FSM pairing on the board top level. Runtime-selectable SPI mode (CPOL/CPHA), parametrised word width, bit order, SCLK divider and number of slave selects. Simple start/busy/done handshake, so the debounced start button or a data-management FSM drives it directly without a register interface.

---
 rtl/spi_master_core.sv | 216 +++++++++++++++++++++
 tb/tb_spi_master_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// SPI master engine: runtime CPOL/CPHA, parametrised width, divider and slave count.
// One DATA_WIDTH-bit transfer per accepted start, reported by a one-cycle done pulse.
module spi_master_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_SS     = 1,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned SEL_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SEL_W-1:0]      ss_sel,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sel_err,
    output logic                  sclk,
    output logic [NUM_SS-1:0]     ss_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_LAG
    } state_e;

    state_e                state_q,   state_d;
    logic [DIV_W-1:0]      div_q,     div_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  trail_q,   trail_d;
    logic                  cpha_q,    cpha_d;
    logic [DATA_WIDTH-1:0] tx_sh_q,   tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  sel_err_q, sel_err_d;
    logic                  sclk_q,    sclk_d;
    logic                  mosi_q,    mosi_d;
    logic [NUM_SS-1:0]     ss_n_q,    ss_n_d;

    logic accept_c;
    logic sel_ok_c;
    logic tick_c;
    logic last_edge_c;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                       input logic                  b);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
    endfunction

    assign accept_c    = start && (state_q == S_IDLE);
    assign sel_ok_c    = 32'(ss_sel) < NUM_SS;
    assign tick_c      = (state_q != S_IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
    // trailing edge that completes the final bit
    assign last_edge_c = trail_q && (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c && sel_ok_c) state_d = S_LEAD;
            S_LEAD: if (tick_c)               state_d = S_XFER;
            S_XFER: if (tick_c && last_edge_c) state_d = S_LAG;
            S_LAG:  if (tick_c)               state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // datapath and output next values
    always_comb begin
        div_d     = '0;
        bit_cnt_d = bit_cnt_q;
        trail_d   = trail_q;
        cpha_d    = cpha_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sel_err_d = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_n_d    = ss_n_q;

        if (state_q != S_IDLE && !tick_c) begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (!sel_ok_c) begin
                        sel_err_d = 1'b1;
                    end else begin
                        cpha_d    = cpha;
                        sclk_d    = cpol;
                        busy_d    = 1'b1;
                        ss_n_d    = ~(NUM_SS'(1) << ss_sel);
                        bit_cnt_d = '0;
                        trail_d   = 1'b0;
                        rx_sh_d   = '0;
                        tx_sh_d   = tx_data;
                        mosi_d    = 1'b0;
                        // CPHA=0 must present the first bit before the first edge
                        if (!cpha) begin
                            mosi_d  = first_bit(tx_data);
                            tx_sh_d = shift_tx(tx_data);
                        end
                    end
                end
            end
            S_LEAD, S_XFER: begin
                if (tick_c) begin
                    sclk_d  = ~sclk_q;
                    trail_d = ~trail_q;
                    if (!trail_q) begin
                        if (cpha_q) begin
                            mosi_d  = first_bit(tx_sh_q);
                            tx_sh_d = shift_tx(tx_sh_q);
                        end else begin
                            rx_sh_d = shift_rx(rx_sh_q, miso);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (cpha_q) begin
                            rx_sh_d = shift_rx(rx_sh_q, miso);
                        end else if (!last_edge_c) begin
                            mosi_d  = first_bit(tx_sh_q);
                            tx_sh_d = shift_tx(tx_sh_q);
                        end
                    end
                end
            end
            S_LAG: begin
                if (tick_c) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    ss_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                end
            end
            default: ;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            bit_cnt_q <= '0;
            trail_q   <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            trail_q   <= trail_d;
            cpha_q    <= cpha_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_err_q <= sel_err_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_n_q    <= ss_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sel_err = sel_err_q;
    assign sclk    = sclk_q;
    assign ss_n    = ss_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench: loopback instance (W=8, DIV=2, 4 selects, MSB first) and
// slave-model instance (W=8, DIV=3, 3 selects, LSB first).
module tb_spi_master_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // instance 0: loopback
    logic       rst0, start0, cpol0, cpha0, busy0, done0, sel_err0, sclk0, mosi0, miso0;
    logic [7:0] tx0, rx0;
    logic [1:0] sel0;
    logic [3:0] ss_n0;
    assign miso0 = mosi0;

    // instance 1: slave returns a fixed word, LSB first, changing on SCLK falling edges
    logic       rst1, start1, cpol1, cpha1, busy1, done1, sel_err1, sclk1, mosi1, miso1;
    logic [7:0] tx1, rx1;
    logic [1:0] sel1;
    logic [2:0] ss_n1;
    logic [7:0] slave_word = 8'h5A;
    int         sl_idx = 0;
    always @(negedge sclk1 or posedge ss_n1[0]) begin
        if (ss_n1[0])        sl_idx <= 0;
        else if (sl_idx < 7) sl_idx <= sl_idx + 1;
    end
    assign miso1 = slave_word[sl_idx[2:0]];

    spi_master_core #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_SS(4), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(rst0), .start(start0), .tx_data(tx0), .cpol(cpol0), .cpha(cpha0),
        .ss_sel(sel0), .busy(busy0), .done(done0), .rx_data(rx0), .sel_err(sel_err0),
        .sclk(sclk0), .ss_n(ss_n0), .mosi(mosi0), .miso(miso0)
    );

    spi_master_core #(.DATA_WIDTH(8), .CLK_DIV(3), .NUM_SS(3), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(rst1), .start(start1), .tx_data(tx1), .cpol(cpol1), .cpha(cpha1),
        .ss_sel(sel1), .busy(busy1), .done(done1), .rx_data(rx1), .sel_err(sel_err1),
        .sclk(sclk1), .ss_n(ss_n1), .mosi(mosi1), .miso(miso1)
    );

    typedef struct {
        int         done_cyc;
        int         n_done;
        int         edges;
        int         viol;
        int         n_selerr;
        logic [3:0] ss_c1;
        logic       busy_c1;
        logic       sclk_c1;
        logic       mosi_c1;
        logic [7:0] rx_done;
        logic       mosi_done;
        logic [3:0] ss_done;
        logic       snap_busy;
        logic [3:0] snap_ss;
        logic       snap_sclk;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts a transfer on instance 0 in the current cycle (cycle 0) and
    // monitors it; returns in the done cycle or when maxc cycles elapse.
    task automatic xfer0(input logic [7:0] tx, input logic cp, input logic ch,
                         input logic [1:0] sel, input int poke_cyc, input int rst_cyc,
                         input int maxc, output res_t r);
        logic ps, pm, pb;
        r = '{default: 0};
        r.done_cyc = -1;
        tx0 = tx; cpol0 = cp; cpha0 = ch; sel0 = sel; start0 = 1'b1;
        ps = sclk0; pm = mosi0; pb = busy0;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk);
            #1;
            start0 = (c == poke_cyc);
            rst0   = (c == rst_cyc);
            if (c == 1) begin
                r.ss_c1 = ss_n0; r.busy_c1 = busy0; r.sclk_c1 = sclk0; r.mosi_c1 = mosi0;
            end
            if (c == rst_cyc + 1) begin
                r.snap_busy = busy0; r.snap_ss = ss_n0; r.snap_sclk = sclk0;
            end
            if (c >= 2 && sclk0 !== ps) r.edges++;
            // mosi may only move together with a non-sampling SCLK edge
            if (busy0 && pb && mosi0 !== pm &&
                !(sclk0 !== ps && sclk0 === (ch ? ~cp : cp))) r.viol++;
            if (sel_err0) r.n_selerr++;
            if (done0) begin
                r.n_done++;
                r.done_cyc = c; r.rx_done = rx0; r.mosi_done = mosi0; r.ss_done = ss_n0;
                break;
            end
            ps = sclk0; pm = mosi0; pb = busy0;
        end
        start0 = 1'b0;
        rst0   = 1'b0;
    endtask

    task automatic chk_xfer(input string tag, input res_t r, input logic [7:0] rx_exp);
        chk({tag, "_done_cyc"}, 32'(r.done_cyc), 32'd35);
        chk({tag, "_rx"},       32'(r.rx_done),  32'(rx_exp));
        chk({tag, "_edges"},    32'(r.edges),    32'd16);
        chk({tag, "_mosi_edge"}, 32'(r.viol),    32'd0);
        chk({tag, "_busy_c1"},  32'(r.busy_c1),  32'd1);
        chk({tag, "_ss_done"},  32'(r.ss_done),  32'hF);
        chk({tag, "_mosi_done"}, 32'(r.mosi_done), 32'd0);
    endtask

    initial begin
        res_t       r, r2;
        int         dc, nb;
        logic [7:0] mw, rx_l;
        logic       ps;

        rst0 = 1'b1; start0 = 1'b0; tx0 = '0; cpol0 = 1'b0; cpha0 = 1'b0; sel0 = '0;
        rst1 = 1'b1; start1 = 1'b0; tx1 = '0; cpol1 = 1'b0; cpha1 = 1'b0; sel1 = '0;
        step(3);
        rst0 = 1'b0;
        rst1 = 1'b0;

        chk("rst_busy0",   32'(busy0),    32'd0);
        chk("rst_done0",   32'(done0),    32'd0);
        chk("rst_sclk0",   32'(sclk0),    32'd0);
        chk("rst_ss_n0",   32'(ss_n0),    32'hF);
        chk("rst_mosi0",   32'(mosi0),    32'd0);
        chk("rst_rx0",     32'(rx0),      32'd0);
        chk("rst_selerr0", 32'(sel_err0), 32'd0);
        chk("rst_ss_n1",   32'(ss_n1),    32'h7);

        // mode 0 loopback
        xfer0(8'hA5, 1'b0, 1'b0, 2'd0, -1, -1, 60, r);
        chk_xfer("m0", r, 8'hA5);
        chk("m0_ss_c1",   32'(r.ss_c1),   32'hE);
        chk("m0_mosi_c1", 32'(r.mosi_c1), 32'd1);
        chk("m0_sclk_c1", 32'(r.sclk_c1), 32'd0);

        // remaining modes, different slave selects
        step(2);
        xfer0(8'h3C, 1'b0, 1'b1, 2'd2, -1, -1, 60, r);
        chk_xfer("m1", r, 8'h3C);
        chk("m1_ss_c1",   32'(r.ss_c1),   32'hB);
        chk("m1_mosi_c1", 32'(r.mosi_c1), 32'd0);
        step(2);
        xfer0(8'h3C, 1'b1, 1'b0, 2'd3, -1, -1, 60, r);
        chk_xfer("m2", r, 8'h3C);
        chk("m2_ss_c1",   32'(r.ss_c1),   32'h7);
        chk("m2_sclk_c1", 32'(r.sclk_c1), 32'd1);
        step(2);
        xfer0(8'h3C, 1'b1, 1'b1, 2'd0, -1, -1, 60, r);
        chk_xfer("m3", r, 8'h3C);
        chk("m3_sclk_c1", 32'(r.sclk_c1), 32'd1);
        step(3);
        chk("idle_sclk_cpol1", 32'(sclk0), 32'd1);
        chk("idle_ss_n",       32'(ss_n0), 32'hF);
        chk("idle_mosi",       32'(mosi0), 32'd0);

        // start while busy is ignored
        xfer0(8'hA5, 1'b0, 1'b0, 2'd1, 10, -1, 60, r);
        chk_xfer("poke", r, 8'hA5);
        chk("poke_selerr", 32'(r.n_selerr), 32'd0);
        step(1);
        chk("poke_no_queue_busy", 32'(busy0), 32'd0);
        chk("poke_no_second_done", 32'(done0), 32'd0);

        // back-to-back: second start in the done cycle
        xfer0(8'h5C, 1'b0, 1'b0, 2'd0, -1, -1, 60, r);
        xfer0(8'hC3, 1'b1, 1'b1, 2'd0, -1, -1, 60, r2);
        chk_xfer("b2b_a", r, 8'h5C);
        chk_xfer("b2b_b", r2, 8'hC3);
        chk("b2b_ss_c1", 32'(r2.ss_c1), 32'hE);

        // reset mid-transfer, then a normal transfer
        step(2);
        xfer0(8'hFF, 1'b0, 1'b0, 2'd0, -1, 12, 40, r);
        chk("rst_mid_busy",  32'(r.snap_busy), 32'd0);
        chk("rst_mid_ss_n",  32'(r.snap_ss),   32'hF);
        chk("rst_mid_sclk",  32'(r.snap_sclk), 32'd0);
        chk("rst_mid_ndone", 32'(r.n_done),    32'd0);
        xfer0(8'h96, 1'b0, 1'b0, 2'd1, -1, -1, 60, r);
        chk_xfer("post_rst", r, 8'h96);
        chk("post_rst_ss_c1", 32'(r.ss_c1), 32'hD);

        // LSB-first against the slave model
        tx1 = 8'h01; cpol1 = 1'b0; cpha1 = 1'b0; sel1 = 2'd0; start1 = 1'b1;
        dc = -1; nb = 0; mw = '0; rx_l = '0; ps = sclk1;
        for (int c = 1; c <= 80 && dc < 0; c++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            if (busy1 && !ps && sclk1 && nb < 8) begin
                mw = {mosi1, mw[7:1]};
                nb++;
            end
            ps = sclk1;
            if (done1) begin
                dc = c;
                rx_l = rx1;
            end
        end
        chk("lsb_done_cyc", 32'(dc),   32'd52);
        chk("lsb_rx",       32'(rx_l), 32'h5A);
        chk("lsb_mosi",     32'(mw),   32'h01);
        chk("lsb_nbits",    32'(nb),   32'd8);

        // out-of-range slave select
        sel1 = 2'd3; start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        chk("selerr_pulse", 32'(sel_err1), 32'd1);
        chk("selerr_busy",  32'(busy1),    32'd0);
        chk("selerr_ss_n",  32'(ss_n1),    32'h7);
        step(1);
        chk("selerr_clear", 32'(sel_err1), 32'd0);
        chk("selerr_busy2", 32'(busy1),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
